// File: rtl/ttt_pkg.sv
// ttt_pkg: shared definitions for the tic-tac-toe turn scheduler.
//   - cell codes on the packed board (2 bits per cell)
//   - winner codes reported by game_fsm
//   - board geometry, scheduler state enum and small helper functions
package ttt_pkg;

    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned BOARD_W   = 2 * NUM_CELLS;
    localparam int unsigned IDX_W     = 4;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P    = 2'b01;
    localparam logic [1:0] WIN_AI   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P_WAIT,
        ST_AI_START,
        ST_AI_WAIT,
        ST_COMMIT,
        ST_SETTLE,
        ST_GAME_OVER
    } state_t;

    // True only for an in-range index whose cell is empty; out-of-range
    // indices never match the loop, so they read as occupied.
    function automatic logic cell_free(input logic [BOARD_W-1:0] board,
                                       input logic [IDX_W-1:0]   idx);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < NUM_CELLS; i++) begin
            if (idx == IDX_W'(i)) begin
                r = (board[2*i +: 2] == CELL_EMPTY);
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/turn_scheduler_if.sv
// turn_scheduler_if: move handshake between the scheduler and game_fsm.
//   mv_valid : move presented (scheduler -> game_fsm)
//   mv_pos   : cell index 0..8 of the move
//   mv_who   : 0 = player, 1 = AI
//   mv_ack   : game_fsm accepted the move (game_fsm -> scheduler)
// master = turn_scheduler side, slave = game_fsm side.
interface turn_scheduler_if;
    import ttt_pkg::*;

    logic             mv_valid;
    logic [IDX_W-1:0] mv_pos;
    logic             mv_who;
    logic             mv_ack;

    modport master (output mv_valid, output mv_pos, output mv_who, input mv_ack);
    modport slave  (input mv_valid, input mv_pos, input mv_who, output mv_ack);
endinterface

// File: rtl/turn_scheduler_first_empty_cell.sv
// first_empty_cell: combinational priority encoder over the board.
//   board     : packed board, cell i = bits [2i+1:2i]
//   idx       : lowest index of an empty cell (0 when none is empty)
//   any_empty : at least one cell is empty
module first_empty_cell
    import ttt_pkg::*;
(
    input  logic [BOARD_W-1:0] board,
    output logic [IDX_W-1:0]   idx,
    output logic               any_empty
);

    always_comb begin
        idx       = '0;
        any_empty = 1'b0;
        for (int unsigned i = 0; i < NUM_CELLS; i++) begin
            if (!any_empty && (board[2*i +: 2] == CELL_EMPTY)) begin
                idx       = IDX_W'(i);
                any_empty = 1'b1;
            end
        end
    end

endmodule

// File: rtl/turn_scheduler.sv
// turn_scheduler: sequences turns of one tic-tac-toe game between the
// player inputs and ai_agent, validating each move and presenting it to
// game_fsm one at a time over the mv handshake.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   new_game          pulse: abandon/finish current game, restart
//   p_req, p_tick     player move request and cell index
//   ai_done, ai_tick  ai_agent completion pulse and chosen cell
//   cell_position     current board (2 bits per cell)
//   winner            game_fsm result: none / player / AI / tie
//   ai_start          pulse requesting an AI move
//   player_turn       high while waiting for the player
//   game_over         high once the game has ended
//   err_invalid       pulse on a rejected player request
//   ai_fault          pulse when a fallback replaces the AI move
//   mv                move handshake (turn_scheduler_if.master)
//
// Optional: define TURN_SCHED_SCORE_EN to add saturating p_wins / ai_wins /
// ties counters (cleared only by rst).
module turn_scheduler
    import ttt_pkg::*;
#(
    parameter int unsigned AI_TIMEOUT      = 64,
    parameter bit          FIRST_MOVER     = 1'b0,
    parameter bit          ALTERNATE_START = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_game,
    input  logic               p_req,
    input  logic [IDX_W-1:0]   p_tick,
    input  logic               ai_done,
    input  logic [IDX_W-1:0]   ai_tick,
    input  logic [BOARD_W-1:0] cell_position,
    input  logic [1:0]         winner,
    output logic               ai_start,
    output logic               player_turn,
    output logic               game_over,
    output logic               err_invalid,
    output logic               ai_fault,
`ifdef TURN_SCHED_SCORE_EN
    output logic [3:0]         p_wins,
    output logic [3:0]         ai_wins,
    output logic [3:0]         ties,
`endif
    turn_scheduler_if.master   mv
);

    localparam int unsigned    TW   = $clog2(AI_TIMEOUT);
    localparam logic [TW-1:0]  TMAX = TW'(AI_TIMEOUT - 1);

    state_t           state, state_n;
    logic             first, first_n;
    logic [TW-1:0]    timer, timer_n;
    logic [IDX_W-1:0] pos_q, pos_n;
    logic             who_q, who_n;

    logic [IDX_W-1:0] fe_idx;
    logic             fe_any;

    first_empty_cell u_first_empty (
        .board     (cell_position),
        .idx       (fe_idx),
        .any_empty (fe_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            first <= FIRST_MOVER;
            timer <= '0;
            pos_q <= '0;
            who_q <= 1'b0;
        end else begin
            state <= state_n;
            first <= first_n;
            timer <= timer_n;
            pos_q <= pos_n;
            who_q <= who_n;
        end
    end

    // Pulses are decoded in the same cycle as their cause; new_game is
    // checked first so it suppresses every pulse and decision.
    always_comb begin
        state_n     = state;
        first_n     = first;
        timer_n     = timer;
        pos_n       = pos_q;
        who_n       = who_q;
        ai_start    = 1'b0;
        err_invalid = 1'b0;
        ai_fault    = 1'b0;

        if (new_game) begin
            state_n = ST_IDLE;
            timer_n = '0;
            if ((state == ST_GAME_OVER) && ALTERNATE_START) begin
                first_n = ~first;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = first ? ST_AI_START : ST_P_WAIT;
                end
                ST_P_WAIT: begin
                    if (p_req) begin
                        if (cell_free(cell_position, p_tick)) begin
                            pos_n   = p_tick;
                            who_n   = 1'b0;
                            state_n = ST_COMMIT;
                        end else begin
                            err_invalid = 1'b1;
                        end
                    end
                end
                ST_AI_START: begin
                    ai_start = 1'b1;
                    timer_n  = '0;
                    state_n  = ST_AI_WAIT;
                end
                ST_AI_WAIT: begin
                    timer_n = timer + 1'b1;
                    if (ai_done && cell_free(cell_position, ai_tick)) begin
                        pos_n   = ai_tick;
                        who_n   = 1'b1;
                        state_n = ST_COMMIT;
                    end else if (ai_done || (timer == TMAX)) begin
                        // A full board leaves through SETTLE, so an empty
                        // cell always exists here.
                        pos_n    = fe_idx;
                        who_n    = 1'b1;
                        ai_fault = 1'b1;
                        state_n  = ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    if (mv.mv_ack) begin
                        state_n = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if ((winner != WIN_NONE) || !fe_any) begin
                        state_n = ST_GAME_OVER;
                    end else if (!who_q) begin
                        state_n = ST_AI_START;
                    end else begin
                        state_n = ST_P_WAIT;
                    end
                end
                ST_GAME_OVER: begin
                    state_n = ST_GAME_OVER;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // Decoded from the state register so rst removes mv_valid at once.
    assign mv.mv_valid = (state == ST_COMMIT);
    assign mv.mv_pos   = pos_q;
    assign mv.mv_who   = who_q;
    assign player_turn = (state == ST_P_WAIT);
    assign game_over   = (state == ST_GAME_OVER);

`ifdef TURN_SCHED_SCORE_EN
    logic game_end;
    assign game_end = !new_game && (state == ST_SETTLE) && (state_n == ST_GAME_OVER);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_wins  <= '0;
            ai_wins <= '0;
            ties    <= '0;
        end else if (game_end) begin
            case (winner)
                WIN_P:   p_wins  <= sat_inc4(p_wins);
                WIN_AI:  ai_wins <= sat_inc4(ai_wins);
                default: ties    <= sat_inc4(ties);   // WIN_TIE or full board
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_turn_scheduler.sv
// tb_turn_scheduler: directed self-checking bench for turn_scheduler.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later.
module tb_turn_scheduler;
    import ttt_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               new_game;
    logic               p_req;
    logic [3:0]         p_tick;
    logic               ai_done;
    logic [3:0]         ai_tick;
    logic [17:0]        cell_position;
    logic [1:0]         winner;
    logic               ai_start;
    logic               player_turn;
    logic               game_over;
    logic               err_invalid;
    logic               ai_fault;
`ifdef TURN_SCHED_SCORE_EN
    logic [3:0]         p_wins;
    logic [3:0]         ai_wins;
    logic [3:0]         ties;
`endif

    int errors = 0;
    int checks = 0;
    int n;

    turn_scheduler_if mv_bus ();

    turn_scheduler #(
        .AI_TIMEOUT      (64),
        .FIRST_MOVER     (1'b0),
        .ALTERNATE_START (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .new_game      (new_game),
        .p_req         (p_req),
        .p_tick        (p_tick),
        .ai_done       (ai_done),
        .ai_tick       (ai_tick),
        .cell_position (cell_position),
        .winner        (winner),
        .ai_start      (ai_start),
        .player_turn   (player_turn),
        .game_over     (game_over),
        .err_invalid   (err_invalid),
        .ai_fault      (ai_fault),
`ifdef TURN_SCHED_SCORE_EN
        .p_wins        (p_wins),
        .ai_wins       (ai_wins),
        .ties          (ties),
`endif
        .mv            (mv_bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_in();
        #1;
    endtask

    initial begin
        rst           = 1'b0;
        new_game      = 1'b0;
        p_req         = 1'b0;
        p_tick        = 4'd0;
        ai_done       = 1'b0;
        ai_tick       = 4'd0;
        cell_position = '0;
        winner        = WIN_NONE;
        mv_bus.mv_ack = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_mv_valid", 32'(mv_bus.mv_valid), 0);
        check("rst_mv_pos", 32'(mv_bus.mv_pos), 0);
        check("rst_mv_who", 32'(mv_bus.mv_who), 0);
        check("rst_ai_start", 32'(ai_start), 0);
        check("rst_player_turn", 32'(player_turn), 0);
        check("rst_game_over", 32'(game_over), 0);
        check("rst_err_invalid", 32'(err_invalid), 0);
        check("rst_ai_fault", 32'(ai_fault), 0);
`ifdef TURN_SCHED_SCORE_EN
        check("rst_scores", 32'({p_wins, ai_wins, ties}), 0);
`endif
        rst = 1'b1;
        tick();                                     // IDLE -> P_WAIT
        check("idle_to_pwait", 32'(player_turn), 1);

        // Legal player move on an empty board
        p_req = 1'b1; p_tick = 4'd0;
        settle_in();
        check("p0_no_err", 32'(err_invalid), 0);
        tick();                                     // -> COMMIT
        p_req = 1'b0;
        check("p0_valid", 32'(mv_bus.mv_valid), 1);
        check("p0_pos", 32'(mv_bus.mv_pos), 0);
        check("p0_who", 32'(mv_bus.mv_who), 0);
        tick();                                     // held without ack
        check("p0_hold_valid", 32'(mv_bus.mv_valid), 1);
        check("p0_hold_pos", 32'(mv_bus.mv_pos), 0);
        cell_position[1:0] = CELL_X;
        mv_bus.mv_ack = 1'b1;
        tick();                                     // -> SETTLE
        mv_bus.mv_ack = 1'b0;
        check("p0_valid_drop", 32'(mv_bus.mv_valid), 0);
        check("settle_no_ai_start", 32'(ai_start), 0);
        tick();                                     // -> AI_START
        check("ai_start_pulse", 32'(ai_start), 1);
        tick();                                     // -> AI_WAIT
        check("ai_start_once", 32'(ai_start), 0);

        // AI picks occupied cell 0 -> fallback to cell 1
        ai_done = 1'b1; ai_tick = 4'd0;
        settle_in();
        check("ai_bad_fault", 32'(ai_fault), 1);
        tick();                                     // -> COMMIT
        ai_done = 1'b0;
        check("ai_bad_fault_end", 32'(ai_fault), 0);
        check("ai_bad_valid", 32'(mv_bus.mv_valid), 1);
        check("ai_bad_pos", 32'(mv_bus.mv_pos), 1);
        check("ai_bad_who", 32'(mv_bus.mv_who), 1);
        cell_position[3:2] = CELL_O;
        mv_bus.mv_ack = 1'b1;
        tick();                                     // -> SETTLE
        mv_bus.mv_ack = 1'b0;
        tick();                                     // -> P_WAIT
        check("back_to_player", 32'(player_turn), 1);

        // Rejected player requests: occupied cell 4, then index 11
        cell_position[9:8] = CELL_O;
        p_req = 1'b1; p_tick = 4'd4;
        settle_in();
        check("occ_err", 32'(err_invalid), 1);
        tick();
        p_tick = 4'd11;
        settle_in();
        check("occ_stay_pwait", 32'(player_turn), 1);
        check("occ_no_valid", 32'(mv_bus.mv_valid), 0);
        check("range_err", 32'(err_invalid), 1);
        tick();
        p_req = 1'b0;
        settle_in();
        check("range_stay_pwait", 32'(player_turn), 1);
        check("range_no_valid", 32'(mv_bus.mv_valid), 0);
        check("err_pulse_end", 32'(err_invalid), 0);
        cell_position[9:8] = CELL_EMPTY;

        // Boundary index 8 accepted
        p_req = 1'b1; p_tick = 4'd8;
        settle_in();
        check("p8_no_err", 32'(err_invalid), 0);
        tick();
        p_req = 1'b0;
        check("p8_pos", 32'(mv_bus.mv_pos), 8);
        cell_position[17:16] = CELL_X;
        mv_bus.mv_ack = 1'b1;
        tick();                                     // -> SETTLE
        mv_bus.mv_ack = 1'b0;
        tick();                                     // -> AI_START
        check("to_ai_start", 32'(ai_start), 1);

        // Silent AI: fallback 64 cycles after ai_start, lowest empty = 2
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (ai_fault) break;
        end
        check("timeout_cycles", 32'(n), 64);
        check("timeout_fault", 32'(ai_fault), 1);
        tick();                                     // -> COMMIT
        check("timeout_valid", 32'(mv_bus.mv_valid), 1);
        check("timeout_pos", 32'(mv_bus.mv_pos), 2);
        check("timeout_who", 32'(mv_bus.mv_who), 1);

        // new_game coinciding with mv_ack in COMMIT
        new_game = 1'b1;
        mv_bus.mv_ack = 1'b1;
        tick();                                     // -> IDLE
        new_game = 1'b0;
        mv_bus.mv_ack = 1'b0;
        check("ng_valid_drop", 32'(mv_bus.mv_valid), 0);
        check("ng_idle_pturn", 32'(player_turn), 0);
        check("ng_idle_ai_start", 32'(ai_start), 0);
        check("ng_idle_over", 32'(game_over), 0);
`ifdef TURN_SCHED_SCORE_EN
        check("ng_scores", 32'({p_wins, ai_wins, ties}), 0);
`endif
        cell_position = '0;
        tick();                                     // first unchanged -> P_WAIT
        check("ng_player_first", 32'(player_turn), 1);

        // Player win
        p_req = 1'b1; p_tick = 4'd3;
        tick();                                     // -> COMMIT
        p_req = 1'b0;
        cell_position[7:6] = CELL_X;
        winner = WIN_P;
        mv_bus.mv_ack = 1'b1;
        tick();                                     // -> SETTLE
        mv_bus.mv_ack = 1'b0;
        check("win_settle_not_over", 32'(game_over), 0);
        tick();                                     // -> GAME_OVER
        check("win_over", 32'(game_over), 1);
        check("win_no_pturn", 32'(player_turn), 0);
`ifdef TURN_SCHED_SCORE_EN
        check("win_p_wins", 32'(p_wins), 1);
        check("win_ai_wins", 32'(ai_wins), 0);
        check("win_ties", 32'(ties), 0);
`endif
        p_req = 1'b1; p_tick = 4'd5;
        ai_done = 1'b1; ai_tick = 4'd6;
        settle_in();
        check("over_ignore_err", 32'(err_invalid), 0);
        check("over_ignore_fault", 32'(ai_fault), 0);
        tick();
        p_req = 1'b0; ai_done = 1'b0;
        check("over_stays", 32'(game_over), 1);
        check("over_no_valid", 32'(mv_bus.mv_valid), 0);

        // new_game from GAME_OVER toggles the first mover to AI
        new_game = 1'b1;
        winner = WIN_NONE;
        cell_position = '0;
        tick();                                     // -> IDLE
        new_game = 1'b0;
        check("ng2_over_clear", 32'(game_over), 0);
        tick();                                     // -> AI_START
        check("ng2_ai_first", 32'(ai_start), 1);
        check("ng2_no_pturn", 32'(player_turn), 0);
`ifdef TURN_SCHED_SCORE_EN
        check("ng2_p_wins_kept", 32'(p_wins), 1);
`endif

        // Legal AI pick, then full board with no winner -> tie
        tick();                                     // -> AI_WAIT
        ai_done = 1'b1; ai_tick = 4'd4;
        settle_in();
        check("ai_ok_no_fault", 32'(ai_fault), 0);
        tick();                                     // -> COMMIT
        ai_done = 1'b0;
        check("ai_ok_pos", 32'(mv_bus.mv_pos), 4);
        check("ai_ok_who", 32'(mv_bus.mv_who), 1);
        cell_position = 18'h15555;
        mv_bus.mv_ack = 1'b1;
        tick();                                     // -> SETTLE
        mv_bus.mv_ack = 1'b0;
        tick();                                     // full board -> GAME_OVER
        check("full_over", 32'(game_over), 1);
`ifdef TURN_SCHED_SCORE_EN
        check("full_ties", 32'(ties), 1);
        check("full_p_wins", 32'(p_wins), 1);
        check("full_ai_wins", 32'(ai_wins), 0);
`endif

        // Asynchronous reset removes a presented move without a clock edge
        new_game = 1'b1;
        cell_position = '0;
        tick();                                     // -> IDLE
        new_game = 1'b0;
        tick();                                     // first toggled back -> P_WAIT
        check("ng3_player_first", 32'(player_turn), 1);
        p_req = 1'b1; p_tick = 4'd7;
        tick();                                     // -> COMMIT
        p_req = 1'b0;
        check("pre_rst_valid", 32'(mv_bus.mv_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", 32'(mv_bus.mv_valid), 0);
        check("async_rst_pos", 32'(mv_bus.mv_pos), 0);
        tick();
        rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
